tcp_state_rd_sched: RTL and testbench

//  Pipelined scheduler sharing the tx-state and recv-state table read ports among NUM_REQ pipeline requesters.

---
 rtl/tcp_pkg.sv | 18 +
 rtl/tcp_state_rd_sched_if.sv | 38 +++
 rtl/tcp_state_rd_tag_fifo.sv | 39 +++
 rtl/tcp_state_rd_sched.sv | 101 ++++++++++
 tb/tb_tcp_state_rd_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared TCP flow-state types and constants
package tcp_pkg;

  localparam int FLOWID_W = 8;
  localparam int STATE_RD_MAX_OUTST = 4;

  typedef struct packed {
    logic [31:0] snd_nxt;
    logic [31:0] snd_una;
    logic [15:0] snd_wnd;
  } tx_state_struct;

  typedef struct packed {
    logic [31:0] rcv_nxt;
    logic [15:0] rcv_wnd;
  } recv_state_entry;

endpackage

// File: rtl/tcp_state_rd_sched_if.sv
// rtl/tcp_state_rd_sched_if.sv - requester and state-table handshakes of the read scheduler
interface tcp_state_rd_sched_if import tcp_pkg::*; #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]          req_val;
  logic [NUM_REQ*FLOWID_W-1:0] req_flowid;
  logic [NUM_REQ-1:0]          req_grant;
  logic                        tx_rd_req_val;
  logic [FLOWID_W-1:0]         tx_rd_req_flowid;
  logic                        tx_rd_req_rdy;
  logic                        rx_rd_req_val;
  logic [FLOWID_W-1:0]         rx_rd_req_flowid;
  logic                        rx_rd_req_rdy;
  logic                        tx_rd_resp_val;
  tx_state_struct              tx_rd_resp_data;
  logic                        tx_rd_resp_rdy;
  logic                        rx_rd_resp_val;
  recv_state_entry             rx_rd_resp_data;
  logic                        rx_rd_resp_rdy;
  logic [NUM_REQ-1:0]          resp_val;
  tx_state_struct              resp_tx_data;
  recv_state_entry             resp_rx_data;
  logic [NUM_REQ-1:0]          resp_rdy;

  modport slave (
    input  req_val, req_flowid, tx_rd_req_rdy, rx_rd_req_rdy,
           tx_rd_resp_val, tx_rd_resp_data, rx_rd_resp_val, rx_rd_resp_data, resp_rdy,
    output req_grant, tx_rd_req_val, tx_rd_req_flowid, rx_rd_req_val, rx_rd_req_flowid,
           tx_rd_resp_rdy, rx_rd_resp_rdy, resp_val, resp_tx_data, resp_rx_data
  );

  modport master (
    output req_val, req_flowid, tx_rd_req_rdy, rx_rd_req_rdy,
           tx_rd_resp_val, tx_rd_resp_data, rx_rd_resp_val, rx_rd_resp_data, resp_rdy,
    input  req_grant, tx_rd_req_val, tx_rd_req_flowid, rx_rd_req_val, rx_rd_req_flowid,
           tx_rd_resp_rdy, rx_rd_resp_rdy, resp_val, resp_tx_data, resp_rx_data
  );
endinterface

// File: rtl/tcp_state_rd_tag_fifo.sv
// rtl/tcp_state_rd_tag_fifo.sv - requester-tag FIFO recording issue order of table reads
module tcp_state_rd_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/tcp_state_rd_sched.sv
// rtl/tcp_state_rd_sched.sv - round-robin scheduler for joined tx/recv state table reads
// Optional statistics counters under TCP_STATE_RD_SCHED_STATS_EN.
module tcp_state_rd_sched import tcp_pkg::*; #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_OUTST = STATE_RD_MAX_OUTST
) (
  input  logic clk,
  input  logic rst_n,
  tcp_state_rd_sched_if.slave bus
`ifdef TCP_STATE_RD_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_grant_cnt,
  output logic [31:0]           stat_full_stall_cnt
`endif
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [CNT_W-1:0] outst_cnt;
  logic [TAG_W-1:0] rr_last;
  logic [TAG_W-1:0] winner;
  logic [TAG_W-1:0] head;
  logic             found;
  logic             issue;
  logic             retire;
  logic             both_val;
  logic             empty;
  logic             full;

  // Rotating priority: scan starts just after the last winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req_val[(int'(rr_last) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = TAG_W'((int'(rr_last) + k) % NUM_REQ);
      end
    end
  end

  assign issue = rst_n && found && bus.tx_rd_req_rdy && bus.rx_rd_req_rdy
              && !full && (outst_cnt < CNT_W'(MAX_OUTST));

  assign bus.req_grant        = issue ? (NUM_REQ'(1) << winner) : '0;
  assign bus.tx_rd_req_val    = issue;
  assign bus.rx_rd_req_val    = issue;
  assign bus.tx_rd_req_flowid = bus.req_flowid[winner*FLOWID_W +: FLOWID_W];
  assign bus.rx_rd_req_flowid = bus.req_flowid[winner*FLOWID_W +: FLOWID_W];

  // Join: each table is only acknowledged when its partner is also presenting.
  assign both_val           = bus.tx_rd_resp_val && bus.rx_rd_resp_val && !empty;
  assign retire             = both_val && bus.resp_rdy[head];
  assign bus.resp_val       = both_val ? (NUM_REQ'(1) << head) : '0;
  assign bus.tx_rd_resp_rdy = !empty && bus.rx_rd_resp_val && bus.resp_rdy[head];
  assign bus.rx_rd_resp_rdy = !empty && bus.tx_rd_resp_val && bus.resp_rdy[head];
  assign bus.resp_tx_data   = bus.tx_rd_resp_data;
  assign bus.resp_rx_data   = bus.rx_rd_resp_data;

  tcp_state_rd_tag_fifo #(.W(TAG_W), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (winner),
    .pop       (retire),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_cnt <= '0;
      rr_last   <= TAG_W'(NUM_REQ - 1);
    end else begin
      if (issue && !retire)      outst_cnt <= outst_cnt + 1'b1;
      else if (retire && !issue) outst_cnt <= outst_cnt - 1'b1;
      if (issue) rr_last <= winner;
    end
  end

  resp_without_tag: assert property (@(posedge clk) disable iff (!rst_n)
    empty |-> !(bus.tx_rd_resp_val || bus.rx_rd_resp_val));

`ifdef TCP_STATE_RD_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant_cnt      <= '0;
      stat_full_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && (winner == TAG_W'(i)) && (stat_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF))
          stat_grant_cnt[i*32 +: 32] <= stat_grant_cnt[i*32 +: 32] + 32'd1;
      end
      if ((|bus.req_val) && (outst_cnt == CNT_W'(MAX_OUTST))
          && (stat_full_stall_cnt != 32'hFFFF_FFFF))
        stat_full_stall_cnt <= stat_full_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tcp_state_rd_sched.sv
// tb/tb_tcp_state_rd_sched.sv - self-checking bench with table models and a tag-queue reference
module tb_tcp_state_rd_sched;
  import tcp_pkg::*;

  localparam int N   = 2;
  localparam int MAX = 4;

  typedef struct { int tag; logic [7:0] fid; } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcp_state_rd_sched_if #(.NUM_REQ(N)) bus ();

`ifdef TCP_STATE_RD_SCHED_STATS_EN
  logic [N*32-1:0] stat_grant_cnt;
  logic [31:0]     stat_full_stall_cnt;
`endif

  tcp_state_rd_sched #(.NUM_REQ(N), .MAX_OUTST(MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef TCP_STATE_RD_SCHED_STATS_EN
    ,
    .stat_grant_cnt      (stat_grant_cnt),
    .stat_full_stall_cnt (stat_full_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  ent_t       mq[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int rr = N - 1;
  int dut_grants = 0;
  int m_grant[N];
  int m_stall = 0;
  bit tx_en = 0;
  bit rx_en = 0;

  function automatic tx_state_struct mk_tx(input logic [7:0] f);
    tx_state_struct r;
    r.snd_nxt = {4{f}} ^ 32'h1357_9BDF;
    r.snd_una = {4{f}} + 32'h100;
    r.snd_wnd = {f, ~f};
    return r;
  endfunction

  function automatic recv_state_entry mk_rx(input logic [7:0] f);
    recv_state_entry r;
    r.rcv_nxt = {f, 8'hC3, ~f, 8'h3C};
    r.rcv_wnd = {~f, f};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); txq.delete(); rxq.delete();
    rr = N - 1;
    m_stall = 0;
    for (int i = 0; i < N; i++) m_grant[i] = 0;
  endtask

  // One clock: present table responses, check every output against the model, then advance.
  task automatic step();
    int win;
    int head;
    bit iss, both, ret, txp, rxp, txo, rxo;
    logic [7:0] txf, rxf;
    bus.tx_rd_resp_val  = tx_en && (txq.size() > 0);
    bus.tx_rd_resp_data = bus.tx_rd_resp_val ? mk_tx(txq[0]) : '0;
    bus.rx_rd_resp_val  = rx_en && (rxq.size() > 0);
    bus.rx_rd_resp_data = bus.rx_rd_resp_val ? mk_rx(rxq[0]) : '0;
    #1;
    win = -1;
    if (bus.tx_rd_req_rdy && bus.rx_rd_req_rdy && mq.size() < MAX)
      for (int k = 1; k <= N; k++)
        if (win < 0 && bus.req_val[(rr + k) % N]) win = (rr + k) % N;
    iss = (win >= 0);
    chk("req_grant", bus.req_grant, iss ? (1 << win) : 0);
    chk("tx_req_val", bus.tx_rd_req_val, iss);
    chk("rx_req_val", bus.rx_rd_req_val, iss);
    if (iss) begin
      chk("tx_req_flowid", bus.tx_rd_req_flowid, bus.req_flowid[win*8 +: 8]);
      chk("rx_req_flowid", bus.rx_rd_req_flowid, bus.req_flowid[win*8 +: 8]);
    end
    head = (mq.size() > 0) ? mq[0].tag : 0;
    both = bus.tx_rd_resp_val && bus.rx_rd_resp_val && (mq.size() > 0);
    chk("resp_val", bus.resp_val, both ? (1 << head) : 0);
    chk("tx_resp_rdy", bus.tx_rd_resp_rdy, (mq.size() > 0) && bus.rx_rd_resp_val && bus.resp_rdy[head]);
    chk("rx_resp_rdy", bus.rx_rd_resp_rdy, (mq.size() > 0) && bus.tx_rd_resp_val && bus.resp_rdy[head]);
    if (both) begin
      chk("resp_tx_data", bus.resp_tx_data, mk_tx(mq[0].fid));
      chk("resp_rx_data", bus.resp_rx_data, mk_rx(mq[0].fid));
    end
    ret = both && bus.resp_rdy[head];
    if (|bus.req_val && mq.size() == MAX) m_stall++;
    txp = bus.tx_rd_req_val && bus.tx_rd_req_rdy;  txf = bus.tx_rd_req_flowid;
    rxp = bus.rx_rd_req_val && bus.rx_rd_req_rdy;  rxf = bus.rx_rd_req_flowid;
    txo = bus.tx_rd_resp_val && bus.tx_rd_resp_rdy;
    rxo = bus.rx_rd_resp_val && bus.rx_rd_resp_rdy;
    if (bus.req_grant != 0) dut_grants++;
    @(posedge clk);
    if (txo) void'(txq.pop_front());
    if (rxo) void'(rxq.pop_front());
    if (txp) txq.push_back(txf);
    if (rxp) rxq.push_back(rxf);
    if (ret) void'(mq.pop_front());
    if (iss) begin
      mq.push_back('{tag: win, fid: bus.req_flowid[win*8 +: 8]});
      rr = win;
      m_grant[win]++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bus.req_val = '0; bus.resp_rdy = '1; tx_en = 1; rx_en = 1;
    for (int i = 0; i < 20 && mq.size() > 0; i++) step();
    chk("drain_done", mq.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_grant"}, bus.req_grant, 0);
    chk({tag, "_tx_val"}, bus.tx_rd_req_val, 0);
    chk({tag, "_rx_val"}, bus.rx_rd_req_val, 0);
    chk({tag, "_resp_val"}, bus.resp_val, 0);
    chk({tag, "_tx_rdy"}, bus.tx_rd_resp_rdy, 0);
    chk({tag, "_rx_rdy"}, bus.rx_rd_resp_rdy, 0);
  endtask

  initial begin
    int g0;
    bus.req_val = 2'b11; bus.req_flowid = '0;
    bus.tx_rd_req_rdy = 1; bus.rx_rd_req_rdy = 1;
    bus.tx_rd_resp_val = 0; bus.tx_rd_resp_data = '0;
    bus.rx_rd_resp_val = 0; bus.rx_rd_resp_data = '0;
    bus.resp_rdy = '1;
    model_reset();
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Both requesters steady, tables always ready and answering next cycle.
    tx_en = 1; rx_en = 1;
    for (int i = 0; i < 10; i++) begin
      bus.req_flowid = 16'($urandom);
      step();
    end
`ifdef TCP_STATE_RD_SCHED_STATS_EN
    chk("stat_grant_t1", stat_grant_cnt, {32'd5, 32'd5});
`endif

    // Tables silent: exactly MAX grants, then one retire re-opens issue.
    drain();
    tx_en = 0; rx_en = 0; bus.req_val = 2'b01; g0 = dut_grants;
    for (int i = 0; i < 7; i++) begin
      bus.req_flowid = 16'($urandom);
      step();
    end
    chk("t2_grant_count", dut_grants - g0, MAX);
    tx_en = 1; rx_en = 1;
    step();
    tx_en = 0; rx_en = 0;
    step();
    chk("t2_resume", dut_grants - g0, MAX + 1);
`ifdef TCP_STATE_RD_SCHED_STATS_EN
    chk("stat_stall", stat_full_stall_cnt, m_stall);
`endif

    // tx response alone is held; rx arrival completes the join.
    drain();
    bus.req_val = 2'b10; bus.req_flowid = 16'h5600;
    tx_en = 0; rx_en = 0;
    step();
    bus.req_val = 2'b00; tx_en = 1;
    for (int i = 0; i < 5; i++) step();
    rx_en = 1;
    step();
    chk("t3_popped", mq.size(), 0);
    step();

    // Head requester back-pressures while issue keeps filling.
    bus.req_val = 2'b01; bus.resp_rdy = 2'b00; tx_en = 1; rx_en = 1;
    for (int i = 0; i < 4; i++) begin
      bus.req_flowid = 16'($urandom);
      step();
    end
    bus.resp_rdy = 2'b11;
    drain();

    // Mid-flight reset, then same-cycle requests go to req 0 first.
    tx_en = 0; rx_en = 0; bus.req_val = 2'b11;
    for (int i = 0; i < 3; i++) step();
    chk("t6_outstanding", mq.size(), 3);
    bus.tx_rd_resp_val = 1; bus.rx_rd_resp_val = 1;
    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    bus.tx_rd_resp_val = 0; bus.rx_rd_resp_val = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_flowid = {8'h34, 8'h12}; bus.req_val = 2'b11;
    #1 chk("t5_first_flowid", bus.tx_rd_req_flowid, 8'h12);
    step();
    bus.req_val = 2'b10;
    #1 chk("t5_second_flowid", bus.rx_rd_req_flowid, 8'h34);
    step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      bus.req_val = 2'($urandom);
      bus.req_flowid = 16'($urandom);
      bus.tx_rd_req_rdy = ($urandom_range(0, 3) != 0);
      bus.rx_rd_req_rdy = ($urandom_range(0, 3) != 0);
      tx_en = ($urandom_range(0, 2) != 0);
      rx_en = ($urandom_range(0, 2) != 0);
      bus.resp_rdy = 2'($urandom);
      step();
    end
    bus.tx_rd_req_rdy = 1; bus.rx_rd_req_rdy = 1;
    drain();
`ifdef TCP_STATE_RD_SCHED_STATS_EN
    chk("stat_grant_end", stat_grant_cnt, {32'(m_grant[1]), 32'(m_grant[0])});
    chk("stat_stall_end", stat_full_stall_cnt, m_stall);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
